// File: rtl/delay_line_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// delay_line_arbiter : round-robin arbiter feeding a shared fixed-latency
//                      delay line, with per-requester outstanding-item limits
// Revision: 1.0
// ---------------------------------------------------------------------------
module delay_line_arbiter #(
  parameter int N_REQ           = 4,
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(N_REQ)-1:0]   out_id
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [DEPTH-1:0] slot_valid_q, slot_valid_d;
  logic [ID_W-1:0]  slot_id_q [DEPTH];
  logic [ID_W-1:0]  slot_id_d [DEPTH];
  logic [WIDTH-1:0] slot_data_q [DEPTH];
  logic [WIDTH-1:0] slot_data_d [DEPTH];

  logic [N_REQ-1:0] eligible;
  logic [ID_W-1:0]  grant_id;
  logic             accept;

  // Eligibility uses the registered count, so a same-cycle return does not help.
  for (genvar i = 0; i < N_REQ; i++) begin : g_elig
    assign eligible[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
  end

  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    accept    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!accept && eligible[(int'(ptr_q) + k) % N_REQ]) begin
        accept   = 1'b1;
        grant_id = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      out_valid[i] = slot_valid_q[wr_ptr_q] && (slot_id_q[wr_ptr_q] == ID_W'(i));
    end
  end

  assign out_id   = slot_id_q[wr_ptr_q];
  assign out_data = slot_data_q[wr_ptr_q];

  always_comb begin
    ptr_d        = ptr_q;
    wr_ptr_d     = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    slot_valid_d = slot_valid_q;
    slot_id_d    = slot_id_q;
    slot_data_d  = slot_data_q;
    slot_valid_d[wr_ptr_q] = accept;
    slot_id_d[wr_ptr_q]    = grant_id;
    slot_data_d[wr_ptr_q]  = req_data[int'(grant_id)*WIDTH +: WIDTH];
    if (accept) begin
      ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept && (grant_id == ID_W'(i)) && !out_valid[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!(accept && (grant_id == ID_W'(i))) && out_valid[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '{default: '0};
      slot_valid_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      slot_valid_q <= slot_valid_d;
    end
  end

  // Payload fields are qualified by slot_valid_q and need no reset.
  always_ff @(posedge clk) begin
    slot_id_q   <= slot_id_d;
    slot_data_q <= slot_data_d;
  end

endmodule
`default_nettype wire
